// File: rtl/fp32_pkg.sv
// Shared FP32 types and constants for the iterative divider.
package fp32_pkg;

  localparam int          FP32_BIAS   = 127;
  localparam int          FP32_EXP_W  = 8;
  localparam int          FP32_FRAC_W = 23;
  localparam logic [31:0] FP32_QNAN   = 32'h7FC0_0000;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } div_state_t;

endpackage

// File: rtl/fp32_classify.sv
// Operand classifier: zero (subnormals flushed), infinity, NaN.
module fp32_classify
  import fp32_pkg::*;
(
  input  fp32_t x_i,
  output logic  is_zero_o,
  output logic  is_inf_o,
  output logic  is_nan_o
);

  logic unused_sign_w;

  assign unused_sign_w = x_i.sign;
  assign is_zero_o     = (x_i.exp == '0);
  assign is_inf_o      = (x_i.exp == '1) && (x_i.frac == '0);
  assign is_nan_o      = (x_i.exp == '1) && (x_i.frac != '0);

endmodule

// File: rtl/fp32_div_seq.sv
// Sequential FP32 divider, restoring radix-2, one quotient bit per cycle.
// Define FP32_DIV_RNE_EN for round-to-nearest-even; default truncates.
module fp32_div_seq
  import fp32_pkg::*;
#(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_dz
);

  localparam int RW = 25;

  function automatic logic [31:0] pack_result(input logic s, input logic signed [9:0] e,
                                              input logic [22:0] f);
    if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0) return {s, 31'd0};
    else return {s, e[7:0], f};
  endfunction

`ifdef FP32_DIV_RNE_EN
  function automatic logic [23:0] round_rne(input logic [22:0] f, input logic g, input logic s);
    return {1'b0, f} + {23'd0, g & (s | f[0])};
  endfunction
`endif

  fp32_t a_w, b_w;
  logic  a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  assign a_w = in_a;
  assign b_w = in_b;

  fp32_classify u_cls_a (.x_i(a_w), .is_zero_o(a_zero), .is_inf_o(a_inf), .is_nan_o(a_nan));
  fp32_classify u_cls_b (.x_i(b_w), .is_zero_o(b_zero), .is_inf_o(b_inf), .is_nan_o(b_nan));

  div_state_t              state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [31:0]             res_q, res_d;
  logic                    dz_q, dz_d;
  logic [23:0]             mb_q, mb_d;
  logic [RW-1:0]           rem_q, rem_d;
  logic [QBITS-1:0]        quo_q, quo_d;
  logic signed [9:0]       exp_q, exp_d;
  logic                    sign_q, sign_d;

  logic                    accept, special, sign_w;
  logic [31:0]             spec_res;
  logic                    spec_dz;
  logic                    ge;
  logic [23:0]             rnext;
  logic [22:0]             frac_n;
  logic signed [9:0]       exp_n;
  logic [31:0]             norm_res;
`ifdef FP32_DIV_RNE_EN
  logic                    guard_n, sticky_n, carry_n;
`endif

  assign accept  = in_valid && (state_q == IDLE);
  assign sign_w  = a_w.sign ^ b_w.sign;
  assign special = a_nan | b_nan | a_zero | b_zero | a_inf | b_inf;

  // Special operands resolve in the accept cycle, in priority order.
  always_comb begin
    spec_dz = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = FP32_QNAN;
    end else if (a_inf) begin
      spec_res = {sign_w, 8'hFF, 23'd0};
    end else if (b_zero) begin
      spec_res = {sign_w, 8'hFF, 23'd0};
      spec_dz  = 1'b1;
    end else begin
      spec_res = {sign_w, 31'd0};
    end
  end

  // Restoring step: remainder stays below 2*divisor, so it fits in 25 bits.
  assign ge    = (rem_q >= {1'b0, mb_q});
  assign rnext = ge ? 24'(rem_q - {1'b0, mb_q}) : rem_q[23:0];

  always_comb begin
    if (quo_q[QBITS-1]) begin
      frac_n = quo_q[QBITS-2:2];
      exp_n  = exp_q;
    end else begin
      frac_n = quo_q[QBITS-3:1];
      exp_n  = exp_q - 10'sd1;
    end
`ifdef FP32_DIV_RNE_EN
    guard_n  = quo_q[QBITS-1] ? quo_q[1] : quo_q[0];
    sticky_n = (quo_q[QBITS-1] & quo_q[0]) | (rem_q != '0);
    {carry_n, frac_n} = round_rne(frac_n, guard_n, sticky_n);
    exp_n = exp_n + $signed({9'd0, carry_n});
`endif
    norm_res = pack_result(sign_q, exp_n, frac_n);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dz_d    = dz_q;
    mb_d    = mb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = sign_w;
          exp_d  = $signed({2'b00, a_w.exp}) - $signed({2'b00, b_w.exp}) + 10'sd127;
          mb_d   = {1'b1, b_w.frac};
          rem_d  = {2'b01, a_w.frac};
          quo_d  = '0;
          cnt_d  = 5'(QBITS - 1);
          if (special) begin
            res_d   = spec_res;
            dz_d    = spec_dz;
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        quo_d = {quo_q[QBITS-2:0], ge};
        rem_d = {rnext, 1'b0};
        if (cnt_q == 5'd0) state_d = NORM;
        else cnt_d = cnt_q - 5'd1;
      end
      NORM: begin
        res_d   = norm_res;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  always_ff @(posedge clk) begin
    mb_q   <= mb_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    exp_q  <= exp_d;
    sign_q <= sign_d;
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = res_q;
  assign out_dz     = dz_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed bench for fp32_div_seq: values, latency, specials, limits, backpressure, reset.
module tb_fp32_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_dz;

  int n_cmp = 0;
  int n_err = 0;

  fp32_div_seq #(.QBITS(26)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dz(out_dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Latency counts clock edges from the accepting edge (inclusive) to out_valid.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_dz, input int exp_lat);
    int k;
    int lat;
    in_a = a; in_b = b; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, out_result, exp_res);
    chk({tag, "_dz"}, {31'd0, out_dz}, {31'd0, exp_dz});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int k;
    int seen;
    logic [31:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_dz", {31'd0, out_dz}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("six_div_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28);
    do_op("neg_six_div_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 28);
    do_op("one_div_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 28);
`ifdef FP32_DIV_RNE_EN
    do_op("one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28);
`else
    do_op("one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 28);
`endif
    do_op("one_div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1);
    do_op("zero_div_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1);
    do_op("neg_one_div_inf", 32'hBF800000, 32'h7F800000, 32'h80000000, 1'b0, 1);
    do_op("inf_div_neg_two", 32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 1);
    do_op("inf_div_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1);
    do_op("nan_div_one", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1);
    do_op("subn_div_one", 32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1);
    do_op("neg_one_div_subn", 32'hBF800000, 32'h00000001, 32'hFF800000, 1'b1, 1);
    do_op("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 28);
    do_op("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 28);

    // Backpressure: result must hold for 5 stalled cycles, then be consumed once.
    in_a = 32'h40C00000; in_b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 60) begin @(posedge clk); #1; k++; end
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    held = 32'h40400000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_res", out_result, held);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_consumed", {31'd0, out_valid}, 32'd0);
    chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);

    // Reset lands at T+10 of an in-flight division.
    in_a = 32'h3F800000; in_b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);
    do_op("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
